mux_16to1_arbiter: RTL

Round-robin arbiter and sequencer for the shared 32-bit 16:1 result mux. It owns the mux `control` select, shares the mux among 16 requesters, and presents the selected operand downstream with a valid/ready handshake. Each requester `i` drives mux input `I_i`. The arbiter decides whose input is routed to `result`, and for how long.

---
 rtl/mux_16to1_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mux_16to1_arbiter.sv
// Round-robin arbiter and sequencer for the shared 32-bit 16:1 result mux.
// Define ARB_LOCK_EN to compile in per-requester burst locking (up to MAX_BURST transfers per grant).
module mux_16to1_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic [15:0] lock,
   input  logic        out_ready,
   output logic [15:0] grant,
   output logic [3:0]  control,
   output logic        out_valid,
   output logic        busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [3:0]  last_q, last_d;
   logic [3:0]  control_q, control_d;
   logic [15:0] grant_q, grant_d;
   logic        valid_q, valid_d;

   logic [3:0]  winner;
   logic        found;
   logic        xfer;
   logic        cont;

`ifdef ARB_LOCK_EN
   localparam logic [4:0] BURST_LAST = 5'(MAX_BURST - 1);
   logic [4:0] burst_cnt_q, burst_cnt_d;

   assign cont = lock[control_q] && req[control_q] && (burst_cnt_q < BURST_LAST);
`else
   localparam int unsigned UNUSED_MAX_BURST = MAX_BURST;
   logic unused_lock;

   assign unused_lock = ^lock;
   assign cont        = 1'b0;
`endif

   assign xfer = valid_q && out_ready;

   // Offset 16 wraps back to last_q itself, so the previous winner is considered last.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int unsigned i = 1; i <= 16; i++) begin
         if (!found && req[4'(last_q + 4'(i))]) begin
            winner = 4'(last_q + 4'(i));
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      control_d = control_q;
      grant_d   = grant_q;
      valid_d   = valid_q;
`ifdef ARB_LOCK_EN
      burst_cnt_d = burst_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d   = S_GRANT;
               control_d = winner;
               grant_d   = 16'(1) << winner;
               valid_d   = 1'b1;
            end
         end
         S_GRANT: begin
            if (xfer && cont) begin
`ifdef ARB_LOCK_EN
               burst_cnt_d = burst_cnt_q + 5'd1;
`endif
            end else if (xfer || !req[control_q]) begin
               // Transfer or abort both hand the turn on to the next requester.
               state_d   = S_IDLE;
               last_d    = control_q;
               control_d = '0;
               grant_d   = '0;
               valid_d   = 1'b0;
`ifdef ARB_LOCK_EN
               burst_cnt_d = '0;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_q    <= 4'hF;
         control_q <= '0;
         grant_q   <= '0;
         valid_q   <= 1'b0;
`ifdef ARB_LOCK_EN
         burst_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         control_q <= control_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
`ifdef ARB_LOCK_EN
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign control   = control_q;
   assign out_valid = valid_q;
   assign busy      = (state_q == S_GRANT);

endmodule
